// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises 10-bit offset-binary samples into 16-bit MCP4911
// write frames over SPI mode 0, with a one-deep pending-sample buffer.
// Optional feature macro: DAC_SYNC_LDAC_EN (when defined, ldac_n pulses low
// during the post-frame gap; otherwise ldac_n is tied low).
//
// Handshake: load is a fire-and-forget strobe with no ready. Every cycle with
// load=1 writes the pending buffer; a still-unsent pending sample is replaced
// (latest wins) and overrun pulses one cycle later, unless the FSM consumes
// the old sample on that same edge.
module dac_spi_tx #(
  parameter int   CLK_DIV = 25,
  parameter logic BUF     = 1'b1,
  parameter logic GA_N    = 1'b1
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [9:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       cs_n,
  output logic       sck,
  output logic       sdi,
  output logic       ldac_n
);

  localparam int              HC_W   = $clog2(CLK_DIV);
  localparam logic [HC_W-1:0] HC_MAX = HC_W'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [HC_W-1:0] hc_q, hc_d;
  logic [4:0]      ec_q, ec_d;
  logic [14:0]     sh_q, sh_d;     // bits still to be sent after the one on sdi
  logic            sck_q, sck_d;
  logic            sdi_q, sdi_d;
  logic            cs_n_q, cs_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            pend_vld_q, pend_vld_d;
  logic [9:0]      pend_data_q, pend_data_d;

  logic            hc_last;
  logic            consume;
  logic [15:0]     frame_w;

  assign hc_last = (hc_q == HC_MAX);
  assign consume = (state_q == S_IDLE) && pend_vld_q;
  assign frame_w = {1'b0, BUF, GA_N, 1'b1, pend_data_q, 2'b00};

  // Next-state logic for the frame FSM and the pending-sample buffer
  always_comb begin
    state_d     = state_q;
    hc_d        = hc_q;
    ec_d        = ec_q;
    sh_d        = sh_q;
    sck_d       = sck_q;
    sdi_d       = sdi_q;
    cs_n_d      = cs_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ovr_d       = 1'b0;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;

    case (state_q)
      S_IDLE: begin
        hc_d = '0;
        ec_d = 5'd0;
        if (pend_vld_q) begin
          sh_d    = frame_w[14:0];
          sdi_d   = frame_w[15];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (hc_last) begin
          hc_d    = '0;
          state_d = S_SHIFT;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (hc_last) begin
          hc_d  = '0;
          sck_d = ~sck_q;
          ec_d  = ec_q + 5'd1;
          // Odd toggle index = falling edge; the last one leaves sdi on bit 0
          if (ec_q[0]) begin
            if (ec_q == 5'd31) begin
              ec_d    = 5'd0;
              state_d = S_HOLD;
            end else begin
              sdi_d = sh_q[14];
              sh_d  = {sh_q[13:0], 1'b0};
            end
          end
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (hc_last) begin
          hc_d    = '0;
          cs_n_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      S_GAP: begin
        if (hc_last) begin
          hc_d    = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        hc_d    = '0;
        ec_d    = 5'd0;
      end
    endcase

    if (consume) pend_vld_d = 1'b0;
    if (load) begin
      pend_data_d = data_in;
      pend_vld_d  = 1'b1;
      ovr_d       = pend_vld_q && !consume;
    end
  end

  // State registers; async reset abandons any frame in flight
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hc_q        <= '0;
      ec_q        <= 5'd0;
      sh_q        <= '0;
      sck_q       <= 1'b0;
      sdi_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      ec_q        <= ec_d;
      sh_q        <= sh_d;
      sck_q       <= sck_d;
      sdi_q       <= sdi_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
    end
  end

`ifdef DAC_SYNC_LDAC_EN
  logic ldac_n_q, ldac_n_d;
  assign ldac_n_d = (state_q != S_GAP);

  // LDAC low for the gap window, lagging the cs_n rise by one cycle
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) ldac_n_q <= 1'b1;
    else        ldac_n_q <= ldac_n_d;
  end
  assign ldac_n = ldac_n_q;
`else
  assign ldac_n = 1'b0;
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = ovr_q;
  assign cs_n    = cs_n_q;
  assign sck     = sck_q;
  assign sdi     = sdi_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: table vectors, corner-case sequences and random load traffic
// for dac_spi_tx at CLK_DIV=2, checked against a frame-level reference model.
module tb_dac_spi_tx;

  localparam int CD        = 2;
  localparam int FRAME_CYC = 35 * CD;
`ifdef DAC_SYNC_LDAC_EN
  localparam logic LDAC_RST = 1'b1;
`else
  localparam logic LDAC_RST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [9:0] data_in = '0;
  logic       busy, done, overrun, cs_n, sck, sdi, ldac_n;

  always #5 clk = ~clk;

  dac_spi_tx #(.CLK_DIV(CD), .BUF(1'b1), .GA_N(1'b1)) dut (
    .sysclk (clk),
    .rst_n  (rst_n),
    .load   (load),
    .data_in(data_in),
    .busy   (busy),
    .done   (done),
    .overrun(overrun),
    .cs_n   (cs_n),
    .sck    (sck),
    .sdi    (sdi),
    .ldac_n (ldac_n)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  // One pending slot; the transmitter can accept a new sample one cycle after
  // the previous frame's done, i.e. FRAME_CYC+1 edges after it started.
  logic [15:0] exp_q[$];
  logic        m_pv = 1'b0;
  logic [9:0]  m_pd = '0;
  int          m_cyc = 0;
  int          m_ready = 0;
  int          exp_ovr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pv    = 1'b0;
      m_ready = 0;
    end else begin
      m_cyc++;
      if (m_pv && m_cyc >= m_ready) begin
        exp_q.push_back(16'h7000 | {4'b0000, m_pd, 2'b00});
        m_pv    = 1'b0;
        m_ready = m_cyc + FRAME_CYC + 1;
      end
      if (load) begin
        if (m_pv) exp_ovr++;
        m_pd = data_in;
        m_pv = 1'b1;
      end
    end
  end

  // ---------------- bus monitor / scoreboard ----------------
  logic [15:0] got_q[$];
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_sdi = 1'b0;
  logic [15:0] shv = '0;
  logic [15:0] last_frame = '0;
  int          cyc = 0, nbits = 0, fall_cyc = 0, rise_cyc = 0;
  bit          in_frame = 0, rise_ok = 0;
  int          ovr_seen = 0, frames_seen = 0, done_seen = 0;

  always @(negedge clk) begin
    logic        exp_l;
    logic [15:0] e;
    cyc++;
    if (!rst_n) begin
      in_frame = 0;
      rise_ok  = 0;
      nbits    = 0;
    end else begin
      if (prev_cs && !cs_n) begin
        in_frame = 1;
        rise_ok  = 0;
        fall_cyc = cyc;
        nbits    = 0;
      end
      if (in_frame && !prev_sck && sck) begin
        shv = {shv[14:0], sdi};
        nbits++;
      end
      if (sdi !== prev_sdi) check("sdi_change_while_sck_low", sck, 1'b0);
      if (cs_n) check("sck_low_when_cs_high", sck, 1'b0);
      if (!prev_cs && cs_n && in_frame) begin
        in_frame = 0;
        rise_ok  = 1;
        rise_cyc = cyc;
        check("sck_pulses", nbits, 16);
        check("cs_low_cycles", cyc - fall_cyc, 34 * CD);
        frames_seen++;
        last_frame = shv;
        got_q.push_back(shv);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", shv, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("frame_vs_model", shv, e);
        end
      end
      if (done) begin
        done_seen++;
        check("done_latency", cyc - fall_cyc, FRAME_CYC);
      end
      if (overrun) ovr_seen++;
`ifdef DAC_SYNC_LDAC_EN
      exp_l = !(rise_ok && (cyc - rise_cyc) >= 1 && (cyc - rise_cyc) <= CD);
`else
      exp_l = 1'b0;
`endif
      check("ldac_n", ldac_n, exp_l);
    end
    prev_cs  = cs_n;
    prev_sck = sck;
    prev_sdi = sdi;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [9:0] d);
    @(negedge clk);
    load    = 1'b1;
    data_in = d;
    @(negedge clk);
    load    = 1'b0;
    data_in = 10'($urandom);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((m_pv || exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_within_budget", (n < budget), 1'b1);
    repeat (4) @(negedge clk);
  endtask

  typedef struct packed {
    logic [9:0]  code;
    logic [15:0] frame;
  } vec_t;
  vec_t vecs[6];

  // Watchdog: the run is a few thousand cycles
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int o0, f0, n;
    vecs[0] = '{code: 10'h2AB, frame: 16'h7AAC};
    vecs[1] = '{code: 10'h000, frame: 16'h7000};
    vecs[2] = '{code: 10'h3FF, frame: 16'h7FFC};
    vecs[3] = '{code: 10'h111, frame: 16'h7444};
    vecs[4] = '{code: 10'h222, frame: 16'h7888};
    vecs[5] = '{code: 10'h155, frame: 16'h7554};

    // 1: reset values, then 50 idle cycles
    repeat (4) @(negedge clk);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sck", sck, 1'b0);
    check("rst_sdi", sdi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_ldac_n", ldac_n, LDAC_RST);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_cs_n", cs_n, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_no_done", done_seen, 0);
    check("idle_no_overrun", ovr_seen, 0);
    check("idle_no_frame", frames_seen, 0);

    // 2/3: table vectors, each from idle; cs_n falls one edge after load edge
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      load    = 1'b1;
      data_in = vecs[i].code;
      @(negedge clk);
      load    = 1'b0;
      data_in = 10'($urandom);
      check("cs_n_before_consume", cs_n, 1'b1);
      @(negedge clk);
      check("cs_n_fall_one_edge", cs_n, 1'b0);
      check("busy_in_frame", busy, 1'b1);
      wait_drain(300);
      check("table_frame", last_frame, vecs[i].frame);
    end
    check("table_no_overrun", ovr_seen, 0);

    // 4: two loads mid-frame; the later one wins, one overrun
    got_q.delete();
    o0 = ovr_seen;
    send(10'h155);
    repeat (20) @(negedge clk);
    send(10'h111);
    send(10'h222);
    wait_drain(400);
    check("ovr_frames", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("ovr_first_frame", got_q[0], 16'h7554);
      check("ovr_winner_frame", got_q[1], 16'h7888);
    end
    check("ovr_pulses", ovr_seen - o0, 1);

    // 5: second load lands on the edge IDLE consumes the first
    got_q.delete();
    o0 = ovr_seen;
    @(negedge clk);
    load    = 1'b1;
    data_in = 10'h0C3;
    @(negedge clk);
    data_in = 10'h13C;
    @(negedge clk);
    load    = 1'b0;
    wait_drain(400);
    check("consume_edge_no_overrun", ovr_seen - o0, 0);
    check("consume_edge_frames", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("consume_edge_first", got_q[0], 16'h730C);
      check("consume_edge_second", got_q[1], 16'h74F0);
    end

    // 6: async reset while sck is high in SHIFT
    send(10'h2F0);
    n = 0;
    while (!sck && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_shift", sck, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cs_n", cs_n, 1'b1);
    check("async_rst_sck", sck, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("abandoned_frame_in_model", exp_q.size(), 1);
    exp_q.delete();
    f0 = frames_seen;
    @(negedge clk);
    load    = 1'b1;
    data_in = 10'h3A5;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("post_rst_no_frame", frames_seen - f0, 0);
    check("post_rst_cs_n", cs_n, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      load    = ($urandom_range(0, 39) == 0);
      data_in = 10'($urandom);
    end
    @(negedge clk);
    load = 1'b0;
    wait_drain(400);

    check("overrun_total", ovr_seen, exp_ovr);
    check("model_queue_empty", exp_q.size(), 0);
    check("done_vs_frames", done_seen, frames_seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
